hv_scan_reg_bist_rsp: RTL and testbench

HV_SCAN_REG_BIST_RSP -- requirements
Module: hv_scan_reg_bist_rsp

---
 rtl/hv_scan_bist_pkg.sv | 21 ++
 rtl/hv_scan_reg_chk.sv | 23 ++
 rtl/hv_scan_reg_bist_rsp.sv | 135 +++++++++++++
 tb/tb_hv_scan_reg_bist_rsp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_scan_bist_pkg.sv
// ---------------------------------------------------------------------------
// hv_scan_bist_pkg
// Shared definitions for the HV scan-register BIST responder:
//   - scan_bist_state_t : responder FSM state encoding
//   - HV_SCAN_REG_NUM_DEF / SCAN_IDX_W : default register count and the
//     matching register-index width
// ---------------------------------------------------------------------------
package hv_scan_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        ACK,
        WAIT_REL
    } scan_bist_state_t;

    localparam int unsigned HV_SCAN_REG_NUM_DEF = 16;
    localparam int unsigned SCAN_IDX_W          = $clog2(HV_SCAN_REG_NUM_DEF);

endpackage

// File: rtl/hv_scan_reg_chk.sv
// ---------------------------------------------------------------------------
// hv_scan_reg_chk
// Combinational integrity check of one scan register read.
//   i_data   : true copy of the register
//   i_data_n : inverted shadow copy
//   i_par    : even-parity bit over i_data
//   o_fail   : 1 when the shadow is not the exact inverse of the true copy,
//              or when parity over {data, par} is odd
// ---------------------------------------------------------------------------
module hv_scan_reg_chk #(
    parameter int unsigned SCAN_REG_W = 8
) (
    input  logic [SCAN_REG_W-1:0] i_data,
    input  logic [SCAN_REG_W-1:0] i_data_n,
    input  logic                  i_par,
    output logic                  o_fail
);

    always_comb begin
        o_fail = (i_data != ~i_data_n) || (^{i_data, i_par});
    end

endmodule

// File: rtl/hv_scan_reg_bist_rsp.sv
// ---------------------------------------------------------------------------
// hv_scan_reg_bist_rsp
// BIST responder: on each request, reads the next scan register (index
// wraps over HV_SCAN_REG_NUM), checks true/shadow/parity consistency and
// returns a one-cycle ack carrying the result. The first failing index is
// captured in a sticky error record.
//
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_bist_en               : BIST window; low aborts and clears everything
//   i_bist_scan_reg_req     : level request, held until ack
//   o_scan_reg_bist_ack/err : one-cycle ack and its check result
//   o_scan_rd_en/addr       : one-cycle register read strobe and index
//   i_scan_rd_data/_n/par   : read response, valid one cycle after rd_en
//   o_scan_err_addr/vld     : first failing index, sticky valid flag
//   i_scan_err_inj          : one-shot error injection arm (only when
//                             HV_SCAN_BIST_ERR_INJ_EN is defined)
//
// Latency: request seen in IDLE in cycle N -> ack in cycle N+3.
// ---------------------------------------------------------------------------
module hv_scan_reg_bist_rsp
    import hv_scan_bist_pkg::*;
#(
    parameter int unsigned HV_SCAN_REG_NUM = HV_SCAN_REG_NUM_DEF,
    parameter int unsigned SCAN_REG_W      = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_bist_en,
    input  logic                               i_bist_scan_reg_req,
    output logic                               o_scan_reg_bist_ack,
    output logic                               o_scan_reg_bist_err,
    output logic                               o_scan_rd_en,
    output logic [$clog2(HV_SCAN_REG_NUM)-1:0] o_scan_rd_addr,
    input  logic [SCAN_REG_W-1:0]              i_scan_rd_data,
    input  logic [SCAN_REG_W-1:0]              i_scan_rd_data_n,
    input  logic                               i_scan_rd_par,
`ifdef HV_SCAN_BIST_ERR_INJ_EN
    input  logic                               i_scan_err_inj,
`endif
    output logic [$clog2(HV_SCAN_REG_NUM)-1:0] o_scan_err_addr,
    output logic                               o_scan_err_vld
);

    localparam int unsigned     IDX_W    = $clog2(HV_SCAN_REG_NUM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HV_SCAN_REG_NUM - 1);

    scan_bist_state_t state;
    logic [IDX_W-1:0] idx;
    logic             chk_fail;
    logic             chk_err;

    hv_scan_reg_chk #(
        .SCAN_REG_W (SCAN_REG_W)
    ) u_chk (
        .i_data   (i_scan_rd_data),
        .i_data_n (i_scan_rd_data_n),
        .i_par    (i_scan_rd_par),
        .o_fail   (chk_fail)
    );

`ifdef HV_SCAN_BIST_ERR_INJ_EN
    logic inj_arm;
    // An armed injection is treated as a real failing check, so it also
    // feeds the sticky error record.
    assign chk_err = chk_fail | inj_arm;
`else
    assign chk_err = chk_fail;
`endif

    // Reset and a closed BIST window share one clear path: both drop any
    // in-flight transaction before it can reach ACK.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_bist_en) begin
            state               <= IDLE;
            idx                 <= '0;
            o_scan_reg_bist_ack <= 1'b0;
            o_scan_reg_bist_err <= 1'b0;
            o_scan_rd_en        <= 1'b0;
            o_scan_rd_addr      <= '0;
            o_scan_err_addr     <= '0;
            o_scan_err_vld      <= 1'b0;
`ifdef HV_SCAN_BIST_ERR_INJ_EN
            inj_arm             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef HV_SCAN_BIST_ERR_INJ_EN
                    if (i_scan_err_inj) begin
                        inj_arm <= 1'b1;
                    end
`endif
                    if (i_bist_scan_reg_req) begin
                        state          <= RD;
                        o_scan_rd_en   <= 1'b1;
                        o_scan_rd_addr <= idx;
                    end
                end
                RD: begin
                    state        <= CHK;
                    o_scan_rd_en <= 1'b0;
                end
                CHK: begin
                    // Result is registered straight into the ack outputs.
                    state               <= ACK;
                    o_scan_reg_bist_ack <= 1'b1;
                    o_scan_reg_bist_err <= chk_err;
                    if (chk_err && !o_scan_err_vld) begin
                        o_scan_err_addr <= idx;
                        o_scan_err_vld  <= 1'b1;
                    end
                end
                ACK: begin
                    state               <= WAIT_REL;
                    o_scan_reg_bist_ack <= 1'b0;
                    o_scan_reg_bist_err <= 1'b0;
                    idx                 <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
`ifdef HV_SCAN_BIST_ERR_INJ_EN
                    inj_arm             <= 1'b0;
`endif
                end
                WAIT_REL: begin
                    if (!i_bist_scan_reg_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hv_scan_reg_bist_rsp.sv
// ---------------------------------------------------------------------------
// tb_hv_scan_reg_bist_rsp
// Self-checking bench for hv_scan_reg_bist_rsp (HV_SCAN_REG_NUM = 16,
// SCAN_REG_W = 8). A behavioural model tracks the expected read index, the
// expected check verdict and the sticky error record. Inputs are driven and
// outputs sampled on the falling clock edge. Define HV_SCAN_BIST_ERR_INJ_EN
// to also exercise the error-injection port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hv_scan_reg_bist_rsp;
    import hv_scan_bist_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = SCAN_IDX_W;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_bist_en;
    logic          req;
    logic          ack;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  rd_data_n;
    logic          rd_par;
    logic [AW-1:0] err_addr;
    logic          err_vld;
`ifdef HV_SCAN_BIST_ERR_INJ_EN
    logic          err_inj;
`endif

    int unsigned n_asrt = 0;
    int unsigned n_fail = 0;

    // Reference model state
    int unsigned m_idx      = 0;
    bit          m_vld      = 1'b0;
    int unsigned m_err_addr = 0;
    bit          m_inj      = 1'b0;

    always #5 i_clk = ~i_clk;

    hv_scan_reg_bist_rsp #(
        .HV_SCAN_REG_NUM (N),
        .SCAN_REG_W      (W)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_bist_en           (i_bist_en),
        .i_bist_scan_reg_req (req),
        .o_scan_reg_bist_ack (ack),
        .o_scan_reg_bist_err (err),
        .o_scan_rd_en        (rd_en),
        .o_scan_rd_addr      (rd_addr),
        .i_scan_rd_data      (rd_data),
        .i_scan_rd_data_n    (rd_data_n),
        .i_scan_rd_par       (rd_par),
`ifdef HV_SCAN_BIST_ERR_INJ_EN
        .i_scan_err_inj      (err_inj),
`endif
        .o_scan_err_addr     (err_addr),
        .o_scan_err_vld      (err_vld)
    );

    // A register read fails when the shadow is not the inverse of the data
    // or when the total number of ones in {data, par} is odd.
    function automatic bit ref_fail(input logic [W-1:0] d, input logic [W-1:0] dn,
                                    input logic p);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
        return (d != ~dn) || ((ones % 2) != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Junk response fails both checks, so a read sampled at the wrong time
    // shows up as an error on a supposedly clean register.
    task automatic set_junk();
        rd_data   = 8'h00;
        rd_data_n = 8'h00;
        rd_par    = 1'b1;
    endtask

    // One request/ack transaction; data is presented only in the cycle after
    // the read strobe. 'hold' keeps req high that many cycles after the ack.
    task automatic xact(input logic [W-1:0] d, input logic [W-1:0] dn, input logic p,
                        input int unsigned hold);
        int unsigned cyc;
        int unsigned rd_cyc;
        bit          got;
        bit          pend;
        bit          rd_seen;
        bit          exp_e;
        cyc = 0; rd_cyc = 0; got = 0; pend = 0; rd_seen = 0;
        exp_e = ref_fail(d, dn, p) || m_inj;
        req = 1'b1;
        while (!got && cyc < 8) begin
            @(negedge i_clk);
            cyc++;
            if (pend) begin
                rd_data = d; rd_data_n = dn; rd_par = p; pend = 0;
            end else begin
                set_junk();
            end
            if (rd_en === 1'b1 && !rd_seen) begin
                check("rd_addr", 32'(rd_addr), m_idx);
                rd_cyc  = cyc;
                rd_seen = 1;
                pend    = 1;
            end
            if (ack === 1'b1) got = 1;
            else check("err_without_ack", 32'(err), 0);
        end
        set_junk();
        check("ack_latency", got ? cyc : 99, 3);
        check("rd_latency", rd_cyc, 1);
        if (exp_e && !m_vld) begin
            m_vld      = 1'b1;
            m_err_addr = m_idx;
        end
        check("ack_err", 32'(err), 32'(exp_e));
        check("err_vld", 32'(err_vld), 32'(m_vld));
        check("err_addr", 32'(err_addr), m_vld ? m_err_addr : 0);
        m_idx = (m_idx + 1) % N;
        m_inj = 1'b0;
        repeat (hold) begin
            @(negedge i_clk);
            check("held_no_ack", 32'(ack), 0);
            check("held_no_rd", 32'(rd_en), 0);
        end
        req = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            check("release_no_ack", 32'(ack), 0);
        end
    endtask

    // Start a request and kill it in CHK, either by closing the BIST window
    // or by reset; no ack may follow and the record must be cleared.
    task automatic abort_in_chk(input bit use_reset);
        req = 1'b1;
        @(negedge i_clk);
        check("abort_rd_en", 32'(rd_en), 1);
        @(negedge i_clk);
        rd_data = 8'hA5; rd_data_n = 8'h5A; rd_par = 1'b0;
        if (use_reset) i_rst_n = 1'b0;
        else           i_bist_en = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("abort_no_ack", 32'(ack), 0);
            check("abort_no_rd", 32'(rd_en), 0);
            check("abort_vld", 32'(err_vld), 0);
            check("abort_addr", 32'(err_addr), 0);
            check("abort_err", 32'(err), 0);
        end
        set_junk();
        req       = 1'b0;
        i_rst_n   = 1'b1;
        i_bist_en = 1'b1;
        @(negedge i_clk);
        m_idx = 0; m_vld = 1'b0; m_err_addr = 0; m_inj = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] dn;
        logic         p;
        int unsigned  mode;

        i_rst_n   = 1'b0;
        i_bist_en = 1'b1;
        req       = 1'b0;
`ifdef HV_SCAN_BIST_ERR_INJ_EN
        err_inj   = 1'b0;
`endif
        set_junk();
        repeat (3) @(negedge i_clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_err_addr", 32'(err_addr), 0);
        check("rst_err_vld", 32'(err_vld), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Clean pass over all registers
        for (int i = 0; i < 16; i++) xact(8'hA5, 8'h5A, 1'b0, 0);
        check("clean_vld", 32'(err_vld), 0);

        // Shadow mismatch on register 5
        for (int i = 0; i < 16; i++) xact(8'hA5, (i == 5) ? 8'h5B : 8'h5A, 1'b0, 0);
        check("mismatch_addr_kept", 32'(err_addr), 5);

        // Request held for 10 cycles after the ack
        xact(8'h3C, 8'hC3, 1'b0, 10);
        xact(8'h3C, 8'hC3, 1'b0, 0);

        // Abort by closing the BIST window in CHK; a request while the
        // window is closed is ignored
        abort_in_chk(1'b0);
        xact(8'hA5, 8'h5A, 1'b0, 0);

        // Wrap-around: 17 requests from index 0
        abort_in_chk(1'b0);
        for (int i = 0; i < 17; i++) xact(8'h81, 8'h7E, 1'b0, 0);

        // Reset in the middle of a transaction
        xact(8'h0F, 8'hF0, 1'b0, 0);
        abort_in_chk(1'b1);
        xact(8'h0F, 8'hF0, 1'b0, 0);

        // Randomized reads: clean, shadow bit flip, or parity flip
        for (int i = 0; i < 40; i++) begin
            d    = W'($urandom);
            dn   = ~d;
            p    = ^d;
            mode = $urandom_range(0, 3);
            if (mode == 1) dn = dn ^ W'(1 << $urandom_range(0, W - 1));
            if (mode == 2) p = ~p;
            xact(d, dn, p, $urandom_range(0, 3));
        end

`ifdef HV_SCAN_BIST_ERR_INJ_EN
        abort_in_chk(1'b0);
        err_inj = 1'b1;
        @(negedge i_clk);
        err_inj = 1'b0;
        m_inj   = 1'b1;
        xact(8'hA5, 8'h5A, 1'b0, 0);
        xact(8'hA5, 8'h5A, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
